// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: writeback buffer in front of the 32x64 register file.
// Accepts single or dual writeback requests, drops writes to r0, and issues
// at most one register-file write per cycle on D_EN/D_Addr/D. S/T reads are
// checked against every pending write: the output register plus queued entries.
// Build option: define WB_FWD_EN to forward pending data onto S_out/T_out.
// Without it, reads pass through and hazard flags a read of a pending register.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 64
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic          wb_dual,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic [AW-1:0] wb_addr2,
  input  logic [DW-1:0] wb_data2,
  output logic          D_EN,
  output logic [AW-1:0] D_Addr,
  output logic [DW-1:0] D,
  input  logic [AW-1:0] S_Addr,
  input  logic [AW-1:0] T_Addr,
  input  logic [DW-1:0] S_rf,
  input  logic [DW-1:0] T_rf,
  output logic [DW-1:0] S_out,
  output logic [DW-1:0] T_out,
  output logic          busy,
  output logic          hazard
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW-1:0] rd_ptr_d, wr_ptr_d, wr_ptr_b;
  logic [CW-1:0] count_q, count_d;
  logic          d_en_q;
  logic [AW-1:0] d_addr_q;
  logic [DW-1:0] d_q;
  logic          accept, push_a, push_b, pop;
  logic [PW-1:0] idx;

  // Ready needs room for a full dual request; the same-cycle pop is ignored.
  assign wb_ready = (DEPTH_C - count_q) >= CW'(2);
  assign accept   = wb_valid & wb_ready;
  assign push_a   = accept & (wb_addr != '0);
  assign push_b   = accept & wb_dual & (wb_addr2 != '0);
  assign pop      = (count_q != '0);

  // Entry B lands right after entry A, or in A's slot when A was dropped.
  always_comb begin
    wr_ptr_b = wr_ptr_q + PW'(push_a);
    wr_ptr_d = wr_ptr_b + PW'(push_b);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
  end

  // Queue storage and pointers; reset discards every pending entry.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_a) begin
        addr_q[wr_ptr_q] <= wb_addr;
        data_q[wr_ptr_q] <= wb_data;
      end
      if (push_b) begin
        addr_q[wr_ptr_b] <= wb_addr2;
        data_q[wr_ptr_b] <= wb_data2;
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write-port register: the head moves here every non-empty cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      d_en_q   <= 1'b0;
      d_addr_q <= '0;
      d_q      <= '0;
    end else begin
      d_en_q <= pop;
      if (pop) begin
        d_addr_q <= addr_q[rd_ptr_q];
        d_q      <= data_q[rd_ptr_q];
      end
    end
  end

  assign D_EN   = d_en_q;
  assign D_Addr = d_addr_q;
  assign D      = d_q;
  assign busy   = (count_q != '0) | d_en_q;

`ifdef WB_FWD_EN
  logic [DW-1:0] s_val, t_val;

  // Youngest match wins: visit output register, then queue oldest to youngest.
  always_comb begin
    s_val = S_rf;
    t_val = T_rf;
    idx   = '0;
    if (d_en_q && (d_addr_q == S_Addr)) s_val = d_q;
    if (d_en_q && (d_addr_q == T_Addr)) t_val = d_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (addr_q[idx] == S_Addr) s_val = data_q[idx];
        if (addr_q[idx] == T_Addr) t_val = data_q[idx];
      end
    end
  end

  assign S_out  = s_val;
  assign T_out  = t_val;
  assign hazard = 1'b0;
`else
  logic s_hit, t_hit;

  // Flag any pending write to a register being read.
  always_comb begin
    s_hit = d_en_q && (d_addr_q == S_Addr);
    t_hit = d_en_q && (d_addr_q == T_Addr);
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (addr_q[idx] == S_Addr) s_hit = 1'b1;
        if (addr_q[idx] == T_Addr) t_hit = 1'b1;
      end
    end
  end

  assign S_out  = S_rf;
  assign T_out  = T_rf;
  assign hazard = (s_hit && (S_Addr != '0)) || (t_hit && (T_Addr != '0));
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Testbench for regfile_wb_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model of pending writes.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 64;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          wb_valid, wb_ready, wb_dual;
  logic [AW-1:0] wb_addr, wb_addr2;
  logic [DW-1:0] wb_data, wb_data2;
  logic          D_EN;
  logic [AW-1:0] D_Addr;
  logic [DW-1:0] D;
  logic [AW-1:0] S_Addr, T_Addr;
  logic [DW-1:0] S_rf, T_rf, S_out, T_out;
  logic          busy, hazard;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          m_q[$];
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_acc;
  int            n_cmp = 0;
  int            n_err = 0;

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dual(wb_dual),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_addr2(wb_addr2), .wb_data2(wb_data2),
    .D_EN(D_EN), .D_Addr(D_Addr), .D(D),
    .S_Addr(S_Addr), .T_Addr(T_Addr), .S_rf(S_rf), .T_rf(T_rf),
    .S_out(S_out), .T_out(T_out), .busy(busy), .hazard(hazard)
  );

  always #5 CLK = ~CLK;

  function automatic bit exp_ready();
    return (DEPTH - m_q.size()) >= 2;
  endfunction

  function automatic bit exp_busy();
    return (m_q.size() != 0) || m_en;
  endfunction

  function automatic bit is_pending(input logic [AW-1:0] a);
    if (a == '0) return 1'b0;
    if (m_en && m_addr == a) return 1'b1;
    foreach (m_q[i]) if (m_q[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input logic [DW-1:0] rf);
    logic [DW-1:0] v;
    v = rf;
`ifdef WB_FWD_EN
    if (a != '0) begin
      if (m_en && m_addr == a) v = m_data;
      foreach (m_q[i]) if (m_q[i].addr == a) v = m_q[i].data;
    end
`endif
    return v;
  endfunction

  function automatic bit exp_hazard();
`ifdef WB_FWD_EN
    return 1'b0;
`else
    return is_pending(S_Addr) || is_pending(T_Addr);
`endif
  endfunction

  // Advance one clock and update the model with the inputs seen at the edge.
  task automatic tick();
    ent_t e;
    @(posedge CLK);
    m_acc = 1'b0;
    if (RESET) begin
      m_q.delete();
      m_en = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      m_acc = wb_valid && exp_ready();
      if (m_q.size() != 0) begin
        e = m_q.pop_front();
        m_en = 1'b1; m_addr = e.addr; m_data = e.data;
      end else begin
        m_en = 1'b0;
      end
      if (m_acc && wb_addr != '0) m_q.push_back('{wb_addr, wb_data});
      if (m_acc && wb_dual && wb_addr2 != '0) m_q.push_back('{wb_addr2, wb_data2});
    end
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_dual = 1'b0;
    wb_addr = '0; wb_data = '0; wb_addr2 = '0; wb_data2 = '0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_cmp++; if (D_EN !== 1'b0) begin n_err++; $display("FAIL reset_den got %0b want 0", D_EN); end
    n_cmp++; if (D_Addr !== '0) begin n_err++; $display("FAIL reset_daddr got %0d want 0", D_Addr); end
    n_cmp++; if (D !== '0) begin n_err++; $display("FAIL reset_d got %h want 0", D); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", wb_ready); end
    n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL reset_hazard got %0b want 0", hazard); end
    RESET = 1'b0;
    // Build up three queued entries, then reset in the middle of the drain.
    wb_valid = 1'b1; wb_dual = 1'b1;
    wb_addr = 5'd1; wb_data = 64'd101; wb_addr2 = 5'd2; wb_data2 = 64'd102;
    tick();
    wb_addr = 5'd3; wb_data = 64'd103; wb_addr2 = 5'd4; wb_data2 = 64'd104;
    tick();
    idle();
    n_cmp++; if (m_q.size() != 3 || D_EN !== 1'b1) begin n_err++; $display("FAIL reset_pre_fill got den=%0b q=%0d want den=1 q=3", D_EN, m_q.size()); end
    #2 RESET = 1'b1;
    #1;
    n_cmp++; if (D_EN !== 1'b0) begin n_err++; $display("FAIL reset_mid_den got %0b want 0", D_EN); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_mid_busy got %0b want 0", busy); end
    n_cmp++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL reset_mid_ready got %0b want 1", wb_ready); end
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (D_EN !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_after_write got den=%0b busy=%0b want 0/0", D_EN, busy); end
    end
  endtask

  task automatic test_single();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 64'hA5;
    tick();
    idle();
    n_cmp++; if (D_EN !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL single_n got den=%0b busy=%0b want 0/1", D_EN, busy); end
    tick();
    n_cmp++; if (D_EN !== 1'b1 || D_Addr !== 5'd5 || D !== 64'hA5) begin n_err++; $display("FAIL single_n1 got %0b/%0d/%h want 1/5/a5", D_EN, D_Addr, D); end
    tick();
    n_cmp++; if (D_EN !== 1'b0 || busy !== 1'b0 || D_Addr !== 5'd5) begin n_err++; $display("FAIL single_n2 got den=%0b busy=%0b addr=%0d want 0/0/5", D_EN, busy, D_Addr); end
  endtask

  task automatic test_dual();
    wb_valid = 1'b1; wb_dual = 1'b1;
    wb_addr = 5'd8; wb_data = 64'd1; wb_addr2 = 5'd9; wb_data2 = 64'd2;
    tick();
    idle();
    tick();
    n_cmp++; if (D_EN !== 1'b1 || D_Addr !== 5'd8 || D !== 64'd1) begin n_err++; $display("FAIL dual_first got %0b/%0d/%0d want 1/8/1", D_EN, D_Addr, D); end
    tick();
    n_cmp++; if (D_EN !== 1'b1 || D_Addr !== 5'd9 || D !== 64'd2) begin n_err++; $display("FAIL dual_second got %0b/%0d/%0d want 1/9/2", D_EN, D_Addr, D); end
    tick();
    n_cmp++; if (D_EN !== 1'b0) begin n_err++; $display("FAIL dual_end got %0b want 0", D_EN); end
    wb_valid = 1'b1; wb_dual = 1'b1;
    wb_addr = 5'd0; wb_data = 64'd3; wb_addr2 = 5'd7; wb_data2 = 64'd4;
    tick();
    idle();
    tick();
    n_cmp++; if (D_EN !== 1'b1 || D_Addr !== 5'd7 || D !== 64'd4) begin n_err++; $display("FAIL dual_zero_a got %0b/%0d/%0d want 1/7/4", D_EN, D_Addr, D); end
    tick();
    n_cmp++; if (D_EN !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL dual_zero_a_end got den=%0b busy=%0b want 0/0", D_EN, busy); end
    wb_valid = 1'b1; wb_dual = 1'b1;
    wb_addr = 5'd0; wb_data = 64'd5; wb_addr2 = 5'd0; wb_data2 = 64'd6;
    tick();
    idle();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dual_zero_both_busy got %0b want 0", busy); end
    tick();
    n_cmp++; if (D_EN !== 1'b0) begin n_err++; $display("FAIL dual_zero_both_den got %0b want 0", D_EN); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] got_a[$];
    logic [DW-1:0] got_d[$];
    int k = 0;
    int cyc = 0;
    bit saw_low = 1'b0;
    while (k < 3 && cyc < 20) begin
      wb_valid = 1'b1; wb_dual = 1'b1;
      wb_addr  = AW'(2*k + 1); wb_data  = 64'h100 + 64'(2*k);
      wb_addr2 = AW'(2*k + 2); wb_data2 = 64'h100 + 64'(2*k + 1);
      n_cmp++; if (wb_ready !== exp_ready()) begin n_err++; $display("FAIL b2b_ready got %0b want %0b", wb_ready, exp_ready()); end
      if (wb_ready === 1'b0) saw_low = 1'b1;
      tick();
      if (m_acc) k++;
      if (D_EN === 1'b1) begin got_a.push_back(D_Addr); got_d.push_back(D); end
      cyc++;
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (D_EN === 1'b1) begin got_a.push_back(D_Addr); got_d.push_back(D); end
    end
    n_cmp++; if (saw_low !== 1'b1) begin n_err++; $display("FAIL b2b_backpressure got saw_low=%0b want 1", saw_low); end
    n_cmp++; if (got_a.size() != 6) begin n_err++; $display("FAIL b2b_count got %0d want 6", got_a.size()); end
    for (int i = 0; i < 6 && i < got_a.size(); i++) begin
      n_cmp++;
      if (got_a[i] !== AW'(i + 1) || got_d[i] !== 64'h100 + 64'(i)) begin
        n_err++; $display("FAIL b2b_order[%0d] got %0d/%h want %0d/%h", i, got_a[i], got_d[i], i + 1, 64'h100 + 64'(i));
      end
    end
  endtask

  task automatic test_fwd_hazard();
    int cyc = 0;
    S_Addr = 5'd3; S_rf = '0; T_Addr = 5'd0; T_rf = 64'h1234;
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 64'd10;
    tick();
    n_cmp++; if (S_out !== exp_read(S_Addr, S_rf) || hazard !== exp_hazard()) begin n_err++; $display("FAIL fwd_first got S=%0d hz=%0b want S=%0d hz=%0b", S_out, hazard, exp_read(S_Addr, S_rf), exp_hazard()); end
    wb_data = 64'd20;
    tick();
    idle();
`ifdef WB_FWD_EN
    n_cmp++; if (S_out !== 64'd20 || hazard !== 1'b0) begin n_err++; $display("FAIL fwd_young got S=%0d hz=%0b want 20/0", S_out, hazard); end
`else
    n_cmp++; if (hazard !== 1'b1 || S_out !== 64'd0) begin n_err++; $display("FAIL hz_pending got hz=%0b S=%0d want 1/0", hazard, S_out); end
`endif
    while (exp_busy() && cyc < 10) begin
      tick();
      n_cmp++; if (S_out !== exp_read(S_Addr, S_rf) || T_out !== exp_read(T_Addr, T_rf) || hazard !== exp_hazard()) begin
        n_err++; $display("FAIL fwd_drain got S=%0d T=%h hz=%0b want S=%0d T=%h hz=%0b", S_out, T_out, hazard, exp_read(S_Addr, S_rf), exp_read(T_Addr, T_rf), exp_hazard());
      end
      cyc++;
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fwd_drain_timeout got busy=%0b want 0", busy); end
    S_rf = 64'h55;
    #1;
    n_cmp++; if (S_out !== 64'h55 || hazard !== 1'b0) begin n_err++; $display("FAIL fwd_passthru got S=%h hz=%0b want 55/0", S_out, hazard); end
    S_Addr = '0; T_Addr = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wb_valid = ($urandom_range(0, 3) != 0);
      wb_dual  = $urandom_range(0, 1);
      wb_addr  = AW'($urandom_range(0, 7));
      wb_addr2 = AW'($urandom_range(0, 7));
      wb_data  = {$urandom, $urandom};
      wb_data2 = {$urandom, $urandom};
      S_Addr   = AW'($urandom_range(0, 7));
      T_Addr   = AW'($urandom_range(0, 7));
      S_rf     = {$urandom, $urandom};
      T_rf     = {$urandom, $urandom};
      tick();
      n_cmp++; if (D_EN !== m_en || D_Addr !== m_addr || D !== m_data) begin n_err++; $display("FAIL rnd_write cyc %0d got %0b/%0d/%h want %0b/%0d/%h", i, D_EN, D_Addr, D, m_en, m_addr, m_data); end
      n_cmp++; if (busy !== exp_busy() || wb_ready !== exp_ready()) begin n_err++; $display("FAIL rnd_status cyc %0d got busy=%0b rdy=%0b want %0b/%0b", i, busy, wb_ready, exp_busy(), exp_ready()); end
      n_cmp++; if (S_out !== exp_read(S_Addr, S_rf) || T_out !== exp_read(T_Addr, T_rf)) begin n_err++; $display("FAIL rnd_read cyc %0d got S=%h T=%h want S=%h T=%h", i, S_out, T_out, exp_read(S_Addr, S_rf), exp_read(T_Addr, T_rf)); end
      n_cmp++; if (hazard !== exp_hazard()) begin n_err++; $display("FAIL rnd_hazard cyc %0d got %0b want %0b", i, hazard, exp_hazard()); end
    end
    idle();
  endtask

  initial begin
    idle();
    S_Addr = '0; T_Addr = '0; S_rf = '0; T_rf = '0;
    m_en = 1'b0; m_addr = '0; m_data = '0; m_acc = 1'b0;
    test_reset();
    test_single();
    test_dual();
    test_back_to_back();
    test_fwd_hazard();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
